// File: rtl/pulse_width_decoder.sv
// Measures the high time of a stretched pulse and recovers the original event.
// Classifies each completed pulse as exact (Strobe), short or long, and flags stuck-high lines.
module pulse_width_decoder #(
  parameter int unsigned n     = 3,
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             sres,
  input  logic             D,
  output logic             Strobe,
  output logic             Err_Short,
  output logic             Err_Long,
  output logic             Stuck,
  output logic             Busy,
  output logic [Width-1:0] Len
);

  localparam logic [Width-1:0] CntMax = '1;
  localparam logic [Width-1:0] NW     = Width'(n);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

  state_t           state, state_nxt;
  logic [Width-1:0] cnt, cnt_nxt, cnt_inc, len_nxt;
  logic             stuck_nxt, strobe_nxt, short_nxt, long_nxt;

  // State and datapath registers; reset discards any pulse in flight
  always_ff @(posedge clk) begin
    if (sres) begin
      state     <= WAIT_LOW;
      cnt       <= '0;
      Len       <= '0;
      Stuck     <= 1'b0;
      Strobe    <= 1'b0;
      Err_Short <= 1'b0;
      Err_Long  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Len       <= len_nxt;
      Stuck     <= stuck_nxt;
      Strobe    <= strobe_nxt;
      Err_Short <= short_nxt;
      Err_Long  <= long_nxt;
    end
  end

  // Saturating increment keeps a stuck line classified as long
  assign cnt_inc = (cnt == CntMax) ? cnt : cnt + Width'(1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    len_nxt    = Len;
    stuck_nxt  = Stuck;
    strobe_nxt = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (!D) state_nxt = IDLE;
      end
      IDLE: begin
        if (D) begin
          state_nxt = HIGH;
          cnt_nxt   = Width'(1);
        end
      end
      HIGH: begin
        if (D) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CntMax) stuck_nxt = 1'b1;
        end else begin
          state_nxt  = IDLE;
          len_nxt    = cnt;
          stuck_nxt  = 1'b0;
          strobe_nxt = (cnt == NW);
          short_nxt  = (cnt < NW);
          long_nxt   = (cnt > NW);
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  assign Busy = (state == HIGH);

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed bench for pulse_width_decoder (n=3, Width=3): expected output vectors are
// queued as each cycle is driven and compared after the following rising edge.
module tb_pulse_width_decoder;

  localparam int unsigned N   = 3;
  localparam int unsigned W   = 3;
  localparam int unsigned SAT = 7;

  logic         clk = 1'b0;
  logic         sres;
  logic         D;
  logic         Strobe, Err_Short, Err_Long, Stuck, Busy;
  logic [W-1:0] Len;

  typedef struct {
    logic [7:0] vec;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         tests  = 0;
  int         failed = 0;
  logic [2:0] exp_len;

  pulse_width_decoder #(.n(N), .Width(W)) dut (
    .clk(clk), .sres(sres), .D(D),
    .Strobe(Strobe), .Err_Short(Err_Short), .Err_Long(Err_Long),
    .Stuck(Stuck), .Busy(Busy), .Len(Len)
  );

  always #5 clk = ~clk;

  // Drive one cycle, queue the expected post-edge outputs, then compare after the edge
  task automatic cyc(input logic d, input logic r, input logic [7:0] e, input string tag);
    exp_t x;
    exp_t y;
    logic [7:0] obs;
    D = d;
    sres = r;
    x.vec = e;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    obs = {Strobe, Err_Short, Err_Long, Stuck, Busy, Len};
    tests++;
    assert (obs === y.vec) else begin
      failed++;
      $error("FAIL %s observed={str,sh,lg,stk,bsy,len}=%b expected=%b", y.tag, obs, y.vec);
    end
  endtask

  function automatic logic [7:0] ev(input logic s, input logic sh, input logic lg,
                                    input logic st, input logic b, input logic [2:0] l);
    return {s, sh, lg, st, b, l};
  endfunction

  task automatic do_reset(input logic d, input string tag);
    exp_len = 3'd0;
    cyc(d, 1'b1, ev(0, 0, 0, 0, 0, 3'd0), tag);
  endtask

  task automatic low(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b0, ev(0, 0, 0, 0, 0, exp_len), tag);
  endtask

  // Pulse of L high samples followed by gap low samples, starting from IDLE
  task automatic pulse(input int L, input int gap, input string tag);
    int          m;
    logic [2:0]  ml;
    for (int i = 1; i <= L; i++)
      cyc(1'b1, 1'b0, ev(0, 0, 0, (i >= int'(SAT)), 1, exp_len), {tag, "_high"});
    m  = (L > int'(SAT)) ? int'(SAT) : L;
    ml = 3'(m);
    exp_len = ml;
    cyc(1'b0, 1'b0, ev(m == int'(N), m < int'(N), m > int'(N), 0, 0, ml), {tag, "_eval"});
    if (gap > 1) low(gap - 1, {tag, "_gap"});
  endtask

  initial begin
    exp_len = 3'd0;
    D = 1'b0;
    sres = 1'b1;

    // 1: exact pulse
    do_reset(1'b0, "t1_reset");
    low(2, "t1_low");
    pulse(3, 2, "t1_exact");

    // 2: short pulses of 1 and 2
    pulse(1, 2, "t2_short1");
    pulse(2, 2, "t2_short2");

    // 3: long pulse of 4, no stuck
    pulse(4, 2, "t3_long4");

    // 4: stuck-high pulse of 10
    pulse(10, 2, "t4_stuck");

    // 5: line high across reset is ignored, then two back-to-back exact pulses
    do_reset(1'b1, "t5_reset_high");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, ev(0, 0, 0, 0, 0, 3'd0), "t5_wait_low");
    low(1, "t5_release");
    pulse(3, 1, "t5_first");
    pulse(3, 1, "t5_second");

    // 6: reset on the 2nd high sample discards the pulse
    low(1, "t6_pre");
    cyc(1'b1, 1'b0, ev(0, 0, 0, 0, 1, exp_len), "t6_high1");
    do_reset(1'b1, "t6_reset_mid");
    cyc(1'b1, 1'b0, ev(0, 0, 0, 0, 0, 3'd0), "t6_high3_ignored");
    low(2, "t6_low");
    pulse(3, 2, "t6_clean");

    // Reset coinciding with the falling edge emits no flag
    cyc(1'b1, 1'b0, ev(0, 0, 0, 0, 1, exp_len), "t7_high1");
    cyc(1'b1, 1'b0, ev(0, 0, 0, 0, 1, exp_len), "t7_high2");
    cyc(1'b1, 1'b0, ev(0, 0, 0, 0, 1, exp_len), "t7_high3");
    do_reset(1'b0, "t7_reset_fall");
    low(2, "t7_after");
    pulse(3, 2, "t7_clean");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pulse_width_decoder.md
# pulse_width_decoder

Receive-side counterpart of the pulse stretcher. It measures the high time of an incoming stretched pulse and recovers the original single-cycle event as `Strobe` when the width equals exactly `n` clocks. It flags short, long and stuck-high pulses and holds the last measured length. It sits at the far end of any link or cross-block path that carries events as `n`-cycle stretched pulses.

## Interface
- `n`, 3, expected pulse width in clocks (n ≥ 1).
- `Width`, 3, counter width; the lowest integer m for which 2^m > n+1, so the saturated count (2^Width−1) is always > n.

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `sres`  in  1  reset, synchronous, active-high; dominates all other inputs.
- `D`  in  1  stretched pulse input, already synchronous to `clk`.
- `Strobe`  out  1  one-cycle pulse when a pulse of exactly `n` clocks has ended.
- `Err_Short`  out  1  one-cycle pulse when a pulse of 1..n−1 clocks has ended.
- `Err_Long`  out  1  one-cycle pulse when a pulse of more than `n` clocks has ended.
- `Stuck`  out  1  level; high while `D` has been high for 2^Width−1 or more samples.
- `Busy`  out  1  level; high while the FSM is in HIGH.
- `Len`  out  Width  length of the last completed pulse, saturating at 2^Width−1.

## Operation
- Registers:
  - `state` ∈ {WAIT_LOW, IDLE, HIGH}.
  - `Cnt[Width-1:0]`.
  - `Len`, `Stuck`, `Strobe`, `Err_Short`, `Err_Long`.
  - All outputs are registers or direct decodes of `state` (`Busy` = state==HIGH).
- On `sres`, all of the following happen:
  - `state` goes to WAIT_LOW.
  - `Cnt` goes to 0 and `Len` goes to 0.
  - All flag outputs go to 0.
- WAIT_LOW:
  - If `D`=0, go to IDLE; otherwise stay.
  - A pulse already in progress when reset releases is never measured or reported.
- IDLE:
  - If `D`=1, go to HIGH and set `Cnt` to 1.
  - If `D`=0, stay.
- HIGH with `D`=1:
  - `Cnt` ← min(`Cnt`+1, 2^Width−1).
  - `Stuck` ← 1 when the new `Cnt` equals 2^Width−1.
- HIGH with `D`=0:
  - Go to IDLE.
  - `Len` ← `Cnt`.
  - Pulse exactly one flag:
    - `Strobe` if `Cnt`==n.
    - `Err_Short` if `Cnt`<n.
    - `Err_Long` if `Cnt`>n.
  - `Stuck` ← 0.
- `Strobe`, `Err_Short` and `Err_Long` are 0 in every cycle other than the one following a falling-edge evaluation. They are mutually exclusive.
- Width compare is unsigned on `Width` bits. A saturated count is always classified as `Err_Long`.

## Timing
- Pulse sampled high on edges k..k+L−1 and low on edge k+L:
  - The flag and `Len`=L are visible from edge k+L until edge k+L+1.
  - Latency is 1 cycle after the first low sample.
  - The flag is high for exactly 1 cycle.
  - `Len` then holds until the next evaluation.
- `Busy` rises after edge k and falls after edge k+L.
- Back-to-back pulses: a single low sample between two pulses is sufficient.
  - The falling-edge evaluation and the return to IDLE happen on the same edge.
  - The next high sample starts a new count.
  - Minimum pulse period is L+1.
- `Stuck` rises after the edge on which the (2^Width−1)-th consecutive high sample is taken. It falls together with the `Err_Long` pulse.
- `sres` mid-pulse:
  - The pulse in progress is discarded and no flag is emitted for it.
  - If `D` is still high, the block waits in WAIT_LOW for the line to go low.
- `sres` in the same cycle as a falling edge: reset wins and no flag is emitted.

## Test plan
All scenarios use n=3, Width=3 (saturation value 7).
1. Reset, `D` low for 2 cycles, then high for 3 samples, then low → `Strobe`=1 for exactly 1 cycle, 1 cycle after the first low sample; `Len`=3; `Err_Short`=`Err_Long`=0; `Busy` high for 3 cycles.
2. High pulses of 1 and 2 samples, separated by 2 low samples → two single-cycle `Err_Short` pulses, with `Len`=1 then `Len`=2; no `Strobe`.
3. High pulse of 4 samples → `Err_Long` for 1 cycle, `Len`=4, `Stuck` never asserted.
4. High for 10 samples, then low → `Stuck` rises after the 7th high sample; `Err_Long` is pulsed and `Stuck` clears on the first low sample; `Len`=7.
5. `D` high during and after `sres` for 5 cycles, then low for 1, high for 3, low for 1, high for 3, low → no flags for the initial high; two `Strobe` pulses 4 cycles apart, `Len`=3 each.
6. `sres` asserted on the 2nd high sample of a 3-sample pulse → all outputs are 0 the next cycle; no `Strobe` or error for that pulse; the next clean 3-sample pulse yields `Strobe`.
